clb_config_loader: RTL
======================

CLB_CONFIG_LOADER -- requirements
Module: clb_config_loader

Interface
REQ-001 Parameter NUM_CLB, default 64, is the maximum number of CLB frames accepted per load (1..255).
REQ-002 Parameter FRAME_W, default 37, is the number of configuration bits per CLB frame.
REQ-003 Port K  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port RST_N  input  1  asynchronous, active-low reset.
REQ-005 Port DIN  input  1  serial bitstream bit, MSB-first.
REQ-006 Port DIN_VALID  input  1  DIN is consumed on a K edge only while this is 1; gaps of any length are legal.
REQ-007 Port CFG_DATA  output  FRAME_W  registered frame payload for the addressed CLB.
REQ-008 Port CFG_ADDR  output  8  frame index 0..N-1 of CFG_DATA.
REQ-009 Port CFG_WE  output  1  one-cycle write strobe qualifying CFG_DATA/CFG_ADDR.
REQ-010 Port DONE  output  1  level; load completed successfully.
REQ-011 Port ERR  output  1  level; load aborted on format or check failure.

Function
REQ-012 FSM states: HUNT, LENGTH, FRAME, CHECK, DONE, ERROR; reset state HUNT.
REQ-013 HUNT: accepted bits shift into an 8-bit window; on window == 8'hA5, go to LENGTH on the same edge; overlapping preamble matches shall be detected.
REQ-014 LENGTH: 8 accepted bits form N, MSB-first; N==0 -> DONE; N>NUM_CLB -> ERROR; else -> FRAME with frame index 0.
REQ-015 FRAME: FRAME_W accepted bits shift into a frame register, MSB-first; a bit counter wraps to 0 after bit FRAME_W-1.
REQ-016 Frame layout MSB->LSB: mux2..mux6 selects (2b each), mem[15:0], comboption[1:0], o2m1_0, o2m2_0, o2m3_0, o2m1_1, o2m2_1, o2m3_1, DQmux1, DQmux2, floporlatch.
REQ-017 A frame is complete on the edge that accepts its last bit (the parity bit when parity is enabled); CFG_WE is 1 for exactly the following cycle with CFG_DATA/CFG_ADDR valid and stable.
REQ-018 After frame N-1 is written, go to DONE; otherwise increment the index and stay in FRAME.
REQ-019 DONE and ERROR are absorbing until RST_N; DIN is ignored in both, and CFG_WE stays 0.
REQ-020 DONE==1 iff state is DONE; ERR==1 iff state is ERROR; both are registered and never 1 together.
REQ-021 CFG_DATA holds its last written value between strobes.

Reset
REQ-022 RST_N low asynchronously forces HUNT, clears all counters and the window, and drives CFG_DATA=0, CFG_ADDR=0, CFG_WE=0, DONE=0, ERR=0.
REQ-023 Reset asserted mid-frame discards the partial frame with no CFG_WE; after release, a new preamble is required.

Configuration
REQ-024 Macro CLB_CFG_PARITY_EN defined: each frame is followed by one parity bit in state CHECK; the frame is written when the parity bit plus FRAME_W data bits have even parity, else the FSM goes to ERROR with no CFG_WE.
REQ-025 Macro CLB_CFG_PARITY_EN undefined: CHECK is not built, frames are exactly FRAME_W bits, and ERR is raised only by the length check.

Structure
REQ-026 Package clb_cfg_pkg holds the FSM state enum, PREAMBLE=8'hA5, FRAME_W, and the field bit positions of REQ-016.
REQ-027 One sub-module, clb_cfg_shifter (serial-in/parallel-out register with bit counter and last-bit flag), is instantiated for both the LENGTH and FRAME fields.

Verification
REQ-028 Stimulus A5, N=2, frames 0x0_0000_0116 and 0x1F_FFFF_FFFF, with correct parity -> two CFG_WE pulses, ADDR 0 then 1, matching data, then DONE=1.
REQ-029 Stimulus junk 0xFA, then A5, N=0 -> no CFG_WE; DONE=1 one cycle after the last length bit.
REQ-030 Stimulus A5, N=NUM_CLB+1 -> ERR=1; 40 further bits produce no CFG_WE.
REQ-031 With parity enabled, the bit of frame 0 is flipped -> ERR=1 and no CFG_WE; with the macro undefined, the same stream without parity bits loads cleanly.
REQ-032 DIN_VALID toggled randomly during a 3-frame load -> results identical to the gap-free load.
REQ-033 RST_N pulsed low at bit 20 of frame 1, then a full 1-frame stream is sent -> all outputs 0 during reset, then one CFG_WE with ADDR 0 and DONE=1.

Source files
------------

// File: rtl/clb_cfg_pkg.sv
// Shared types and constants for the CLB configuration loader: FSM states,
// preamble byte and the bit positions of each field inside a CLB frame.
package clb_cfg_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LENGTH,
        ST_FRAME,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } cfg_state_e;

    localparam logic [7:0] PREAMBLE = 8'hA5;
    localparam int         FRAME_W  = 37;

    // Frame layout, MSB first; two-bit fields are given by their LSB.
    localparam int MUX2_LSB       = 35;
    localparam int MUX3_LSB       = 33;
    localparam int MUX4_LSB       = 31;
    localparam int MUX5_LSB       = 29;
    localparam int MUX6_LSB       = 27;
    localparam int MEM_MSB        = 26;
    localparam int MEM_LSB        = 11;
    localparam int COMBOPTION_LSB = 9;
    localparam int O2M1_0_BIT     = 8;
    localparam int O2M2_0_BIT     = 7;
    localparam int O2M3_0_BIT     = 6;
    localparam int O2M1_1_BIT     = 5;
    localparam int O2M2_1_BIT     = 4;
    localparam int O2M3_1_BIT     = 3;
    localparam int DQMUX1_BIT     = 2;
    localparam int DQMUX2_BIT     = 1;
    localparam int FLOPORLATCH_BIT = 0;

endpackage

// File: rtl/clb_cfg_shifter.sv
// Serial-in/parallel-out register with a wrapping bit counter. data already
// includes the bit being accepted this cycle, so a field is usable on its last edge.
module clb_cfg_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] data,
    output logic         last
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  q;
    logic [CW-1:0] cnt;

    // While idle, data is the held contents, letting a trailing check reuse it.
    assign data = en ? {q[W-2:0], din} : q;
    assign last = en && (cnt == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            cnt <= '0;
        end else begin
            if (en)
                q <= data;
            if (clr)
                cnt <= '0;
            else if (en)
                cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/clb_config_loader.sv
// Serial CLB configuration loader: hunts for the preamble, reads a frame count,
// then streams FRAME_W-bit frames out as write strobes. Define CLB_CFG_PARITY_EN
// to require an even-parity bit after every frame.
module clb_config_loader #(
    parameter int NUM_CLB = 64,
    parameter int FRAME_W = clb_cfg_pkg::FRAME_W
) (
    input  logic               K,
    input  logic               RST_N,
    input  logic               DIN,
    input  logic               DIN_VALID,
    output logic [FRAME_W-1:0] CFG_DATA,
    output logic [7:0]         CFG_ADDR,
    output logic               CFG_WE,
    output logic               DONE,
    output logic               ERR
);
    import clb_cfg_pkg::*;

    cfg_state_e         state, state_nxt;
    logic [7:0]         window, win_nxt;
    logic [7:0]         n_reg, idx;
    logic [7:0]         len_data;
    logic               len_last;
    logic [FRAME_W-1:0] frm_data;
    logic               frm_last;
    logic               wr, last_frame;

    assign win_nxt    = {window[6:0], DIN};
    assign last_frame = (idx + 8'd1 == n_reg);

    clb_cfg_shifter #(.W(8)) u_len (
        .clk  (K),
        .rst_n(RST_N),
        .clr  (state != ST_LENGTH),
        .en   (DIN_VALID && state == ST_LENGTH),
        .din  (DIN),
        .data (len_data),
        .last (len_last)
    );

    clb_cfg_shifter #(.W(FRAME_W)) u_frm (
        .clk  (K),
        .rst_n(RST_N),
        .clr  (state != ST_FRAME),
        .en   (DIN_VALID && state == ST_FRAME),
        .din  (DIN),
        .data (frm_data),
        .last (frm_last)
    );

    always_comb begin
        state_nxt = state;
        wr        = 1'b0;
        case (state)
            ST_HUNT:
                if (DIN_VALID && win_nxt == PREAMBLE)
                    state_nxt = ST_LENGTH;
            ST_LENGTH:
                if (len_last) begin
                    if (len_data == 8'd0)
                        state_nxt = ST_DONE;
                    else if (len_data > 8'(NUM_CLB))
                        state_nxt = ST_ERROR;
                    else
                        state_nxt = ST_FRAME;
                end
`ifdef CLB_CFG_PARITY_EN
            ST_FRAME:
                if (frm_last)
                    state_nxt = ST_CHECK;
            ST_CHECK:
                if (DIN_VALID) begin
                    if (^{frm_data, DIN}) begin
                        state_nxt = ST_ERROR;
                    end else begin
                        wr        = 1'b1;
                        state_nxt = last_frame ? ST_DONE : ST_FRAME;
                    end
                end
`else
            ST_FRAME:
                if (frm_last) begin
                    wr        = 1'b1;
                    state_nxt = last_frame ? ST_DONE : ST_FRAME;
                end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge K or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_HUNT;
            window   <= '0;
            n_reg    <= '0;
            idx      <= '0;
            CFG_DATA <= '0;
            CFG_ADDR <= '0;
            CFG_WE   <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_HUNT && DIN_VALID)
                window <= win_nxt;
            if (len_last)
                n_reg <= len_data;
            if (state == ST_LENGTH)
                idx <= '0;
            else if (wr)
                idx <= idx + 8'd1;
            CFG_WE <= wr;
            if (wr) begin
                CFG_DATA <= frm_data;
                CFG_ADDR <= idx;
            end
            DONE <= (state_nxt == ST_DONE);
            ERR  <= (state_nxt == ST_ERROR);
        end
    end

endmodule
